// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: RV32I opcodes, funct3
// size/sign encodings, the controller state type and a legality helper.
package lsu_ctrl_pkg;

   // Major opcodes that route an instruction to the LSU
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   // funct3 access size/sign encodings shared by loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Width of the timeout counter, enough for the largest TIMEOUT of 255
   localparam int CNT_W = 8;

   // Controller states
   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_ACCESS = 2'd1,
      LSU_RESP   = 2'd2
   } lsu_state_t;

   // Stores accept only the signed sizes; loads also accept the unsigned
   // byte and halfword variants.
   function automatic logic funct3Legal(input logic isStore, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      if (isStore) begin
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      end else begin
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the core-facing request/response signals and the data-memory
// port. The LSU sits on the slave side; the core and memory model drive
// the master side.
interface lsu_ctrl_if #(
   parameter int ADDR_W = 32
) ();

   logic              req_valid;
   logic              req_ready;
   logic              is_store;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       store_data;
   logic              done;
   logic [31:0]       load_data;
   logic              misaligned;
   logic              illegal;
   logic              fault;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   // View seen by the load/store unit itself
   modport slave (
      input  req_valid, is_store, funct3, addr, store_data, mem_ack, mem_rdata,
      output req_ready, done, load_data, misaligned, illegal, fault,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   // View seen by the surrounding core pipeline and data memory
   modport master (
      output req_valid, is_store, funct3, addr, store_data, mem_ack, mem_rdata,
      input  req_ready, done, load_data, misaligned, illegal, fault,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

endinterface

// File: rtl/lsu_ctrl_align.sv
// Purely combinational byte-lane logic for the LSU: byte enables and
// replicated write data for stores, lane extraction plus sign/zero
// extension for loads, and the legality/alignment checks.
module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  logic        isStore,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addrLo,
   input  logic [31:0] storeData,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] loadData,
   output logic        misaligned,
   output logic        illegal
);

   logic [1:0]  sizeCode;
   logic [7:0]  byteLane;
   logic [15:0] halfLane;
   logic        rawMisaligned;

   assign sizeCode = funct3[1:0];

   // Legality first; an illegal access never reports misalignment so the
   // controller sees a single, prioritised error flag.
   always_comb begin
      illegal       = !funct3Legal(isStore, funct3);
      rawMisaligned = 1'b0;
      case (sizeCode)
         2'b01:   rawMisaligned = addrLo[0];
         2'b10:   rawMisaligned = (addrLo != 2'b00);
         default: rawMisaligned = 1'b0;
      endcase
      misaligned = rawMisaligned && !illegal;
   end

   // Store lanes: enables follow the addressed bytes, data is replicated
   // so the memory can pick whichever lane the enables select.
   always_comb begin
      be    = 4'b1111;
      wdata = storeData;
      if (isStore) begin
         case (sizeCode)
            2'b00: begin
               be    = 4'b0001 << addrLo;
               wdata = {4{storeData[7:0]}};
            end
            2'b01: begin
               be    = 4'b0011 << {addrLo[1], 1'b0};
               wdata = {2{storeData[15:0]}};
            end
            default: begin
               be    = 4'b1111;
               wdata = storeData;
            end
         endcase
      end
   end

   // Load lanes: pick the addressed byte/halfword and extend it.
   always_comb begin
      byteLane = rdata[7:0];
      case (addrLo)
         2'd0:    byteLane = rdata[7:0];
         2'd1:    byteLane = rdata[15:8];
         2'd2:    byteLane = rdata[23:16];
         default: byteLane = rdata[31:24];
      endcase
      halfLane = addrLo[1] ? rdata[31:16] : rdata[15:0];
      loadData = 32'd0;
      case (funct3)
         F3_B:    loadData = {{24{byteLane[7]}}, byteLane};
         F3_H:    loadData = {{16{halfLane[15]}}, halfLane};
         F3_W:    loadData = rdata;
         F3_BU:   loadData = {24'd0, byteLane};
         F3_HU:   loadData = {16'd0, halfLane};
         default: loadData = 32'd0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one address from the ALU at a time,
// runs a single request/acknowledge memory transaction with a timeout,
// and returns a one-cycle done pulse with the extended load data and
// error flags.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic        clk,
   input  logic        rst,
   lsu_ctrl_if.slave   bus
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   lsu_state_t        state_q, state_d;
   logic [CNT_W-1:0]  count_q;
   logic              isStore_q;
   logic [2:0]        funct3_q;
   logic [1:0]        addrLo_q;
   logic [ADDR_W-3:0] wordAddr_q;
   logic [31:0]       storeData_q;
   logic [31:0]       rdata_q;
   logic              misaligned_q;
   logic              illegal_q;
   logic              fault_q;

   logic        handshake;
   logic        inIdle;
   logic        timeoutHit;
   logic        alignIsStore;
   logic [2:0]  alignFunct3;
   logic [1:0]  alignAddrLo;
   logic [31:0] alignStoreData;
   logic [3:0]  alignBe;
   logic [31:0] alignWdata;
   logic [31:0] alignLoad;
   logic        alignMisaligned;
   logic        alignIllegal;

   logic              reqReady;
   logic              doneOut;
   logic [31:0]       loadDataOut;
   logic              misalignedOut;
   logic              illegalOut;
   logic              faultOut;
   logic              memReq;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [3:0]        memBe;
   logic [31:0]       memWdata;

   assign inIdle     = (state_q == LSU_IDLE);
   assign handshake  = inIdle && bus.req_valid;
   assign timeoutHit = (count_q == LIMIT);

   // In IDLE the checks look at the incoming request so the error decision
   // is made on the handshake; afterwards the latched copy keeps enables,
   // write data and load extraction stable.
   assign alignIsStore   = inIdle ? bus.is_store     : isStore_q;
   assign alignFunct3    = inIdle ? bus.funct3       : funct3_q;
   assign alignAddrLo    = inIdle ? bus.addr[1:0]    : addrLo_q;
   assign alignStoreData = inIdle ? bus.store_data   : storeData_q;

   lsu_align uAlign (
      .isStore    (alignIsStore),
      .funct3     (alignFunct3),
      .addrLo     (alignAddrLo),
      .storeData  (alignStoreData),
      .rdata      (rdata_q),
      .be         (alignBe),
      .wdata      (alignWdata),
      .loadData   (alignLoad),
      .misaligned (alignMisaligned),
      .illegal    (alignIllegal)
   );

   // State register; reset drops the memory request immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LSU_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: errors skip the memory access; an ack on the last allowed
   // cycle still wins over the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE: begin
            if (handshake) begin
               if (alignIllegal || alignMisaligned) begin
                  state_d = LSU_RESP;
               end else begin
                  state_d = LSU_ACCESS;
               end
            end
         end
         LSU_ACCESS: begin
            if (bus.mem_ack || timeoutHit) begin
               state_d = LSU_RESP;
            end
         end
         LSU_RESP: begin
            state_d = LSU_IDLE;
         end
         default: begin
            state_d = LSU_IDLE;
         end
      endcase
   end

   // Request capture, timeout counting and read-data capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q      <= '0;
         isStore_q    <= 1'b0;
         funct3_q     <= 3'd0;
         addrLo_q     <= 2'd0;
         wordAddr_q   <= '0;
         storeData_q  <= 32'd0;
         rdata_q      <= 32'd0;
         misaligned_q <= 1'b0;
         illegal_q    <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         if (handshake) begin
            count_q      <= '0;
            isStore_q    <= bus.is_store;
            funct3_q     <= bus.funct3;
            addrLo_q     <= bus.addr[1:0];
            wordAddr_q   <= bus.addr[ADDR_W-1:2];
            storeData_q  <= bus.store_data;
            rdata_q      <= 32'd0;
            misaligned_q <= alignMisaligned;
            illegal_q    <= alignIllegal;
            fault_q      <= 1'b0;
         end else if (state_q == LSU_ACCESS) begin
            count_q <= count_q + 1'b1;
            if (bus.mem_ack) begin
               rdata_q <= bus.mem_rdata;
            end else if (timeoutHit) begin
               fault_q <= 1'b1;
            end
         end
      end
   end

   // Outputs decoded from state; everything except req_ready idles at zero
   always_comb begin
      reqReady      = 1'b0;
      doneOut       = 1'b0;
      loadDataOut   = 32'd0;
      misalignedOut = 1'b0;
      illegalOut    = 1'b0;
      faultOut      = 1'b0;
      memReq        = 1'b0;
      memWe         = 1'b0;
      memAddr       = '0;
      memBe         = 4'd0;
      memWdata      = 32'd0;
      case (state_q)
         LSU_IDLE: begin
            reqReady = 1'b1;
         end
         LSU_ACCESS: begin
            memReq   = 1'b1;
            memWe    = isStore_q;
            memAddr  = {wordAddr_q, 2'b00};
            memBe    = alignBe;
            memWdata = alignWdata;
         end
         LSU_RESP: begin
            doneOut       = 1'b1;
            misalignedOut = misaligned_q;
            illegalOut    = illegal_q;
            faultOut      = fault_q;
            if (!isStore_q && !misaligned_q && !illegal_q && !fault_q) begin
               loadDataOut = alignLoad;
            end
         end
         default: begin
            reqReady = 1'b0;
         end
      endcase
   end

   assign bus.req_ready  = reqReady;
   assign bus.done       = doneOut;
   assign bus.load_data  = loadDataOut;
   assign bus.misaligned = misalignedOut;
   assign bus.illegal    = illegalOut;
   assign bus.fault      = faultOut;
   assign bus.mem_req    = memReq;
   assign bus.mem_we     = memWe;
   assign bus.mem_addr   = memAddr;
   assign bus.mem_be     = memBe;
   assign bus.mem_wdata  = memWdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a short timeout so the fault path is
// reached quickly. Inputs change and outputs are checked on falling edges.
module tb_lsu_ctrl;

   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;
   int   cyc;

   lsu_ctrl_if #(.ADDR_W(32)) bus ();

   lsu_ctrl #(
      .TIMEOUT (4),
      .ADDR_W  (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a wait never resolves
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000ns");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Presents one request for a single handshake cycle; returns on the
   // falling edge right after the handshake edge.
   task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd);
      @(negedge clk);
      bus.is_store   = st;
      bus.funct3     = f3;
      bus.addr       = a;
      bus.store_data = sd;
      bus.req_valid  = 1'b1;
      @(negedge clk);
      bus.req_valid  = 1'b0;
   endtask

   // Single-cycle memory acknowledge; returns on the following falling edge
   task automatic ackMem(input logic [31:0] rd);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rd;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'd0;
   endtask

   // Directed sequence
   initial begin
      testsRun       = 0;
      testsFailed    = 0;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.is_store   = 1'b0;
      bus.funct3     = 3'd0;
      bus.addr       = 32'd0;
      bus.store_data = 32'd0;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = 32'd0;

      repeat (2) @(negedge clk);
      checkOutput("rst_req_ready", bus.req_ready, 1);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_mem_req", bus.mem_req, 0);
      checkOutput("rst_load_data", bus.load_data, 0);
      rst = 1'b0;

      // LB at 0x103: top byte 0x80 sign-extends
      applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'd0);
      checkOutput("lb_mem_req", bus.mem_req, 1);
      checkOutput("lb_mem_addr", bus.mem_addr, 32'h0000_0100);
      checkOutput("lb_mem_be", bus.mem_be, 4'b1111);
      checkOutput("lb_mem_we", bus.mem_we, 0);
      ackMem(32'h80FF_1234);
      checkOutput("lb_done", bus.done, 1);
      checkOutput("lb_load_data", bus.load_data, 32'hFFFF_FF80);
      checkOutput("lb_flags", {bus.misaligned, bus.illegal, bus.fault}, 0);
      @(negedge clk);
      checkOutput("lb_done_pulse", bus.done, 0);
      checkOutput("lb_back_ready", bus.req_ready, 1);

      // LHU / LH at 0x202 with upper half 0xBEEF
      applyStimulus(1'b0, 3'b101, 32'h0000_0202, 32'd0);
      ackMem(32'hBEEF_0000);
      checkOutput("lhu_load_data", bus.load_data, 32'h0000_BEEF);
      applyStimulus(1'b0, 3'b001, 32'h0000_0202, 32'd0);
      ackMem(32'hBEEF_0000);
      checkOutput("lh_load_data", bus.load_data, 32'hFFFF_BEEF);

      // LBU at 0x101 picks byte 1
      applyStimulus(1'b0, 3'b100, 32'h0000_0101, 32'd0);
      ackMem(32'h80FF_1234);
      checkOutput("lbu_load_data", bus.load_data, 32'h0000_0012);

      // SB at 0x301
      applyStimulus(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5);
      checkOutput("sb_mem_we", bus.mem_we, 1);
      checkOutput("sb_mem_be", bus.mem_be, 4'b0010);
      checkOutput("sb_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
      checkOutput("sb_mem_addr", bus.mem_addr, 32'h0000_0300);
      ackMem(32'h1234_5678);
      checkOutput("sb_done", bus.done, 1);
      checkOutput("sb_flags", {bus.misaligned, bus.illegal, bus.fault}, 0);
      checkOutput("sb_load_data", bus.load_data, 0);

      // SH at 0x22 uses the upper halfword lanes
      applyStimulus(1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD);
      checkOutput("sh_mem_be", bus.mem_be, 4'b1100);
      checkOutput("sh_mem_wdata", bus.mem_wdata, 32'hABCD_ABCD);
      ackMem(32'd0);
      checkOutput("sh_done", bus.done, 1);

      // LW at 0x402 is misaligned: no memory access, done one cycle later
      applyStimulus(1'b0, 3'b010, 32'h0000_0402, 32'd0);
      checkOutput("lw_mis_mem_req", bus.mem_req, 0);
      checkOutput("lw_mis_done", bus.done, 1);
      checkOutput("lw_mis_flag", bus.misaligned, 1);
      checkOutput("lw_mis_illegal", bus.illegal, 0);
      checkOutput("lw_mis_load_data", bus.load_data, 0);
      @(negedge clk);
      checkOutput("lw_mis_after", {bus.done, bus.misaligned, bus.mem_req}, 0);

      // Store with reserved funct3 011
      applyStimulus(1'b1, 3'b011, 32'h0000_0000, 32'hFFFF_FFFF);
      checkOutput("st_ill_done", bus.done, 1);
      checkOutput("st_ill_flag", bus.illegal, 1);
      checkOutput("st_ill_mis", bus.misaligned, 0);

      // Load funct3 110 at 0x2: illegal outranks misaligned
      applyStimulus(1'b0, 3'b110, 32'h0000_0002, 32'd0);
      checkOutput("ld_ill_prio", {bus.done, bus.illegal, bus.misaligned}, 3'b110);

      // Timeout: ack never arrives
      applyStimulus(1'b0, 3'b010, 32'h0000_0500, 32'd0);
      cyc = 0;
      while (bus.mem_req === 1'b1 && cyc < 10) begin
         cyc++;
         @(negedge clk);
      end
      checkOutput("to_req_cycles", cyc, 4);
      checkOutput("to_done", bus.done, 1);
      checkOutput("to_fault", bus.fault, 1);
      checkOutput("to_load_data", bus.load_data, 0);

      // Ack on the fourth access cycle still succeeds
      applyStimulus(1'b0, 3'b010, 32'h0000_0504, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("late_ack_req", bus.mem_req, 1);
      ackMem(32'hCAFE_F00D);
      checkOutput("late_ack_done", bus.done, 1);
      checkOutput("late_ack_fault", bus.fault, 0);
      checkOutput("late_ack_data", bus.load_data, 32'hCAFE_F00D);

      // Reset in the middle of an access
      applyStimulus(1'b0, 3'b010, 32'h0000_0600, 32'd0);
      checkOutput("rst_acc_req_before", bus.mem_req, 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_acc_mem_req", bus.mem_req, 0);
      checkOutput("rst_acc_ready", bus.req_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1111_1111;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      checkOutput("rst_stray_ack_done", bus.done, 0);
      @(negedge clk);
      checkOutput("rst_stray_ack_done2", bus.done, 0);

      // SW at 0x10 after the reset completes normally
      applyStimulus(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
      checkOutput("sw_mem_addr", bus.mem_addr, 32'h0000_0010);
      checkOutput("sw_mem_be", bus.mem_be, 4'b1111);
      checkOutput("sw_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      checkOutput("sw_mem_we", bus.mem_we, 1);
      ackMem(32'd0);
      checkOutput("sw_done", bus.done, 1);
      checkOutput("sw_flags", {bus.misaligned, bus.illegal, bus.fault}, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU in the RV32I core.
- Takes the effective address the ALU produces for LOAD/STORE (rs1 + imm), plus funct3 and rs2 store data.
- Runs a single-outstanding request/acknowledge transaction on the data-memory port.
- Returns a byte-lane-extracted, sign- or zero-extended load result to writeback, and flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ack before raising fault (range 2..255).
- ADDR_W, 32, width of address buses.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  ALU result is a LOAD/STORE address to execute
- req_ready  out  1  high only in IDLE; transfer occurs on req_valid & req_ready
- is_store  in  1  1 = STORE opcode, 0 = LOAD opcode
- funct3  in  3  access size/sign (RV32I encoding)
- addr  in  ADDR_W  effective address from ALU rd
- store_data  in  32  rs2 value
- done  out  1  one-cycle pulse, transaction finished (success or error)
- load_data  out  32  extended load result, valid while done=1, else 0
- misaligned  out  1  with done: address misaligned for size
- illegal  out  1  with done: reserved funct3
- fault  out  1  with done: mem_ack not received within TIMEOUT
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion, single cycle
- mem_rdata  in  32  read word, valid when mem_ack=1

Behaviour:
- Reset (async, immediate): state IDLE, timeout counter 0. All outputs 0 except req_ready=1. Reset during ACCESS drops mem_req the same instant; any pending ack is ignored.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On handshake, latch is_store, funct3, addr[1:0], word address and store_data.
  - Check legality:
    - Loads: funct3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
    - Stores: funct3 in {000 SB, 001 SH, 010 SW}.
  - Check alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - If illegal or misaligned: go to RESP with the corresponding flag set; no memory access. Illegal takes priority over misaligned.
  - Otherwise: go to ACCESS.
- ACCESS:
  - mem_req=1. mem_addr, mem_we, mem_be, mem_wdata are stable for the whole state.
  - Counter increments each cycle.
  - mem_ack=1: capture mem_rdata, go to RESP.
  - Counter reaches TIMEOUT-1 without ack: go to RESP with fault=1.
  - mem_ack arriving in the same cycle as the timeout limit counts as success.
- RESP: done=1 for exactly one cycle with load_data and flags, then IDLE. Flags are 0 whenever done=0.
- Minimum latency: handshake at cycle N; mem_req in N+1; ack in N+1 gives done in N+2. Error paths give done in N+1.
- Back-to-back: a new handshake is possible in the cycle after RESP. req_valid while not ready is ignored and nothing is latched.
- Byte enables:
  - SB: 4'b0001 << addr[1:0]
  - SH: 4'b0011 << {addr[1],1'b0}
  - SW: 4'b1111
  - Loads: 4'b1111
- Store data: SB replicates byte 4x, SH replicates halfword 2x, SW passes through.
- Load extraction:
  - Byte lane = mem_rdata[8*addr[1:0] +: 8]; halfword lane = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend to 32 bits. LBU/LHU zero-extend. LW passes through.
- Stores: load_data=0 on done.
- Error responses: load_data=0.

Decomposition:
- util.v gains:
  - funct3 constants `F3_B, `F3_H, `F3_W, `F3_BU, `F3_HU
  - state encodings `LSU_IDLE, `LSU_ACCESS, `LSU_RESP
- Existing `LOAD/`STORE opcodes stay there.
- One combinational sub-module, lsu_align: from funct3, addr[1:0], store_data and mem_rdata it produces be, wdata, load_data, misaligned and illegal. The FSM and timeout counter live in lsu_ctrl.

Test Plan:
- LB at addr 0x103, mem_rdata 0x80FF_1234 with ack in first ACCESS cycle -> mem_addr 0x100, mem_be 1111; done 2 cycles after handshake; load_data 0xFFFF_FF80.
- LHU at 0x202, rdata 0xBEEF_0000 -> load_data 0x0000_BEEF. Same access as LH -> 0xFFFF_BEEF.
- SB at 0x301, store_data 0x0000_00A5 -> mem_we=1, mem_be 0010, mem_wdata 0xA5A5_A5A5, mem_addr 0x300; done with no flags.
- LW at 0x402 -> no mem_req ever; done one cycle after handshake with misaligned=1 and load_data=0. Store with funct3=011 -> illegal=1.
- TIMEOUT=4, mem_ack held 0 -> mem_req high exactly 4 cycles, then done with fault=1. With ack on the 4th cycle -> success, fault=0.
- Assert rst during ACCESS -> mem_req=0 and req_ready=1 immediately. A late mem_ack produces no done. Next SW at 0x10 completes normally.
